// File: rtl/aoi_pkg.sv
// Shared definitions for AOI gate sweep checkers: FSM states, last vector
// and the golden AOI_2_1 function.
package aoi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0] VEC_LAST = 8'hFF;

    // Bit order {A,B,C,D,E,F,G,H}: v[7]=A ... v[0]=H.
    function automatic logic aoi_2_1_exp(input logic [7:0] v);
        return ~((v[7] & v[6]) | (v[5] & v[4]) | (v[3] & v[2]) | (v[1] & v[0]));
    endfunction

endpackage

// File: rtl/aoi_2_1_golden.sv
// Combinational reference model of the AOI_2_1 gate; swap this module to
// retarget the checker at another gate variant.
module aoi_2_1_golden
    import aoi_pkg::*;
(
    input  logic [7:0] stim,
    output logic       y_exp
);

    assign y_exp = aoi_2_1_exp(stim);

endmodule

// File: rtl/aoi_2_1_sweep_checker.sv
// Exhaustive stimulus/response checker for the AOI_2_1 gate: sweeps all 256
// input vectors, waits a settle time, samples Y and compares to the golden model.
module aoi_2_1_sweep_checker
    import aoi_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [7:0]       stim,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       first_fail_vec,
    output logic             first_fail_valid
);

    // The down-counter only ever holds SETTLE_CYCLES-1 .. 0.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;

    state_t           r_state;
    state_t           w_state_next;
    logic [SW-1:0]    r_settle_cnt;
    logic [7:0]       r_stim;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_err_count;
    logic [7:0]       r_ff_vec;
    logic             r_ff_valid;

    logic             w_y_exp;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_err_next;

    aoi_2_1_golden u_golden (
        .stim  (r_stim),
        .y_exp (w_y_exp)
    );

    assign w_mismatch = (r_state == SAMPLE) && (dut_y != w_y_exp);
    assign w_err_next = r_err_count + {{(CNT_W-1){1'b0}}, w_mismatch};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (SETTLE_CYCLES > 0) begin
                    w_state_next = SETTLE;
                end else begin
                    w_state_next = SAMPLE;
                end
            end
            SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (r_stim == VEC_LAST) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = DRIVE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle_cnt <= '0;
            r_stim       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_ff_vec     <= '0;
            r_ff_valid   <= 1'b0;
        end else begin
            // Status flags are registered from the next state so they line up
            // with the state they describe.
            r_busy <= (w_state_next == DRIVE) || (w_state_next == SETTLE) ||
                      (w_state_next == SAMPLE);
            r_done <= (w_state_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_stim      <= '0;
                        r_err_count <= '0;
                        r_ff_valid  <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                DRIVE: begin
                    r_settle_cnt <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (r_settle_cnt != '0) begin
                        r_settle_cnt <= r_settle_cnt - SW'(1);
                    end
                end
                SAMPLE: begin
                    r_err_count <= w_err_next;
                    if (w_mismatch && !r_ff_valid) begin
                        r_ff_vec   <= r_stim;
                        r_ff_valid <= 1'b1;
                    end
                    // stim holds VEC_LAST after the sweep rather than wrapping.
                    if (r_stim != VEC_LAST) begin
                        r_stim <= r_stim + 8'd1;
                    end else begin
                        r_pass <= (w_err_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stim             = r_stim;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_valid = r_ff_valid;

endmodule

// File: doc/aoi_2_1_sweep_checker.md
Name: aoi_2_1_sweep_checker

Overview:
- Sequential stimulus/response engine for the 8-input AOI_2_1 gate: the checking end of the gate's test interface.
- Drives all 256 input combinations onto the gate, waits a programmable settle time, then samples Y and compares it against a built-in golden model.
- Reports mismatch count, first failing vector and a pass flag.
- Sits beside the AOI_2_1 instance in board-level self-test and in simulation regressions.

Parameters:
- SETTLE_CYCLES, 2, clock cycles between driving a vector and sampling dut_y; 0 is legal.
- CNT_W, 9, width of err_count; must be at least 9 so that 256 errors fit.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled only in IDLE; begins a sweep.
- stim  out  8  {A,B,C,D,E,F,G,H}; stim[7]=A, stim[0]=H; drives the gate inputs.
- dut_y  in  1  Y output of the gate under test.
- busy  out  1  high from the DRIVE state through the SAMPLE state.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  high when the last completed sweep had zero mismatches; held until the next start.
- err_count  out  CNT_W  number of mismatching vectors in the current or last sweep.
- first_fail_vec  out  8  stim value of the first mismatch.
- first_fail_valid  out  1  high once first_fail_vec has been captured.

Behaviour:
- Golden model: Y_exp = ~((A&B)|(C&D)|(E&F)|(G&H)).
- Reset (async, active-high), in any state including mid-sweep:
  - state=IDLE.
  - stim=0, busy=0, done=0, pass=0.
  - err_count=0, first_fail_vec=0, first_fail_valid=0.
  - settle counter=0.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Rising edge with start=1 → DRIVE.
  - On that same edge: stim=0, err_count=0, first_fail_valid=0, pass=0.
- DRIVE: lasts one cycle; stim is stable. Next state is SETTLE if SETTLE_CYCLES>0, otherwise SAMPLE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, counted by a down-counter loaded in DRIVE. Then → SAMPLE.
- SAMPLE (one cycle):
  - Compare dut_y against Y_exp(stim).
  - On a mismatch, err_count increments. If first_fail_valid=0, capture first_fail_vec=stim and set first_fail_valid=1.
  - If stim==8'hFF → DONE. Otherwise stim increments by 1 and the FSM → DRIVE.
- DONE (one cycle):
  - done=1.
  - pass is registered as (err_count==0), using the final count including the last SAMPLE.
  - Then → IDLE.
- Stim timing: stim changes only on the SAMPLE→DRIVE edge and the IDLE→DRIVE edge. It never wraps during a sweep and holds 8'hFF after the sweep until the next start.
- Timing per vector: 2+SETTLE_CYCLES cycles. DONE is entered 256*(2+SETTLE_CYCLES) edges after the start edge; with the default this is 1024.
- start while busy or in DONE: ignored. It is not queued.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- dut_y is sampled only in SAMPLE; its value in all other states is don't-care.
- err_count cannot exceed 256, so no saturation logic is needed with CNT_W≥9.
- All outputs are registered; there is no combinational path from dut_y to any output.

Decomposition:
- Shared package aoi_pkg holds:
  - the state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE);
  - the constant VEC_LAST=8'hFF;
  - the golden function aoi_2_1_exp(8-bit) → 1-bit.
  The package is reused by other AOI checkers.
- One natural sub-module, aoi_2_1_golden: a combinational reference model instantiated inside the checker. It can later be swapped per gate variant.

Test Plan:
- Connect a correct AOI_2_1 model, default params, pulse start → done pulses exactly 1024 cycles after the start edge; pass=1, err_count=0, first_fail_valid=0.
- Tie dut_y=0 → err_count=81 (vectors with no AND pair high); first_fail_vec=8'h00; pass=0.
- Tie dut_y=1 → err_count=175; first_fail_vec=8'h03 (G&H high); pass=0.
- SETTLE_CYCLES=0 with a correct model → done 512 cycles after start; pass=1. Also check that the stim sequence is 0..255 with each value held 2 cycles.
- Assert rst at vector 8'h40 mid-sweep → on the same edge all outputs return to reset values and the FSM is in IDLE. A new start then sweeps from 8'h00.
- Pulse start again at vector 8'h10 while busy → no effect: the sweep continues and done appears once at the expected cycle.
